// File: rtl/ysyx_22051013_icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and line refill.
// Define YSYX_22051013_ICACHE_PERF_EN to add the perf_hit/perf_miss/perf_stall counters.
module ysyx_22051013_icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BEATS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic [63:0] resp_pc,
  input  logic        flush,
  input  logic        fence_i,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rlast
`ifdef YSYX_22051013_ICACHE_PERF_EN
  ,
  output logic [63:0] perf_hit,
  output logic [63:0] perf_miss,
  output logic [63:0] perf_stall
`endif
);

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, INVAL} state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q;
  logic [WAY_W-1:0]   victim_q;
  logic               full_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [31:0]        inst_q;
  logic               kill_q;
  logic               fence_pend_q;
  logic [IDX_W-1:0]   inval_q;

  logic [63:0]        data_mem  [WAYS][SETS][LINE_BEATS];
  logic [TAG_W-1:0]   tag_mem   [WAYS][SETS];
  logic [WAYS-1:0]    valid_q   [SETS];
  logic [WAY_W-1:0]   rr_q      [SETS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [BEAT_W-1:0]  pc_beat;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               set_full;
  logic [63:0]        hit_word;
  logic [31:0]        hit_inst;
  logic               accept;
  logic               refill_done;

  assign idx      = pc_q[OFF_W +: IDX_W];
  assign tag      = pc_q[63 -: TAG_W];
  assign pc_beat  = (LINE_BEATS > 1) ? pc_q[3 +: BEAT_W] : '0;
  assign mem_addr = {pc_q[63:OFF_W], {OFF_W{1'b0}}};
  assign accept   = req_valid && req_ready;
  assign refill_done = (state_q == REFILL) && mem_rvalid && mem_rlast;

  // Descending scans so the lowest-numbered matching way is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    victim   = rr_q[idx];
    set_full = &valid_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_mem[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) victim = WAY_W'(w);
    end
  end

  assign hit_word = data_mem[hit_way][idx][pc_beat];
  assign hit_inst = pc_q[2] ? hit_word[63:32] : hit_word[31:0];

  // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_inst     = '0;
    resp_pc       = '0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !flush && !fence_pend_q;
        if (req_valid && req_ready)    state_d = LOOKUP;
        else if (fence_pend_q || fence_i) state_d = INVAL;
      end
      LOOKUP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_inst  = hit_inst;
          resp_pc    = pc_q;
          if (resp_ready) begin
            req_ready = !fence_pend_q;
            state_d   = (req_valid && req_ready) ? LOOKUP : IDLE;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (mem_rvalid && mem_rlast) state_d = (kill_q || flush) ? IDLE : RESP;
      end
      RESP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          resp_valid = 1'b1;
          resp_inst  = inst_q;
          resp_pc    = pc_q;
          if (resp_ready) state_d = IDLE;
        end
      end
      INVAL: begin
        if (inval_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_inst     = '0;
      resp_pc       = '0;
      mem_req_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fence_pend_q <= 1'b0;
      kill_q       <= 1'b0;
      inval_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == INVAL) fence_pend_q <= 1'b0;
      else if (fence_i)                        fence_pend_q <= 1'b1;
      if (state_q == LOOKUP) kill_q <= 1'b0;
      else if ((state_q == MISS_REQ || state_q == REFILL) && flush) kill_q <= 1'b1;
      inval_q <= (state_q == INVAL) ? inval_q + 1'b1 : '0;
    end
  end

  // Datapath registers carry no reset: they are only observed once the FSM qualifies them.
  always_ff @(posedge clk) begin
    if (accept) pc_q <= req_pc;
    if (state_q == LOOKUP && state_d == MISS_REQ) begin
      victim_q <= victim;
      full_q   <= set_full;
    end
    if (state_q == MISS_REQ) beat_q <= '0;
    else if (state_q == REFILL && mem_rvalid) beat_q <= beat_q + 1'b1;
    if (state_q == LOOKUP && state_d == RESP) inst_q <= hit_inst;
    else if (state_q == REFILL && mem_rvalid && beat_q == pc_beat)
      inst_q <= pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end

  // NOTE: data and tag arrays are not reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL && mem_rvalid) data_mem[victim_q][idx][beat_q] <= mem_rdata;
    if (!rst && refill_done) tag_mem[victim_q][idx] <= tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (refill_done) begin
      valid_q[idx][victim_q] <= 1'b1;
      if (full_q) rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
    end else if (state_q == INVAL) begin
      valid_q[inval_q] <= '0;
    end
  end

`ifdef YSYX_22051013_ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit   <= '0;
      perf_miss  <= '0;
      perf_stall <= '0;
    end else begin
      if (state_q == LOOKUP && hit && !flush) perf_hit <= perf_hit + 64'd1;
      if (state_q == MISS_REQ && mem_req_ready) perf_miss <= perf_miss + 64'd1;
      if (resp_valid && !resp_ready) perf_stall <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051013_icache_nway.sv
// Self-checking bench for ysyx_22051013_icache_nway: directed scenarios plus random fetches
// against a set/tag reference model and a deterministic memory image.
module tb_ysyx_22051013_icache_nway;
  localparam int WAYS = 2, SETS = 64, LINE_BEATS = 2;
  localparam longint unsigned LINE_BYTES = LINE_BEATS * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_pc;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_inst;
  logic [63:0] resp_pc;
  logic        flush, fence_i;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_rvalid, mem_rlast;
  logic [63:0] mem_rdata;
`ifdef YSYX_22051013_ICACHE_PERF_EN
  logic [63:0] perf_hit, perf_miss, perf_stall;
`endif

  always #5 clk = ~clk;

  ysyx_22051013_icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BEATS(LINE_BEATS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_pc(resp_pc),
    .flush(flush), .fence_i(fence_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
`ifdef YSYX_22051013_ICACHE_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_stall(perf_stall)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mem_req_cnt = 0;
  int cur_beat = 0;
  logic [63:0] last_mem_addr = '0;

  bit          m_valid [SETS][WAYS];
  logic [63:0] m_tag   [SETS][WAYS];
  int          m_rr    [SETS];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h5a5a_1234, ~a[31:0] + 32'h0000_0101};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] d;
    d = beat_data({pc[63:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  // Returns 1 on hit; on miss installs the line using lowest-invalid / round-robin choice.
  function automatic bit model_access(input logic [63:0] pc);
    int s;
    int v;
    logic [63:0] t;
    s = int'((pc / LINE_BYTES) % SETS);
    t = pc / (LINE_BYTES * SETS);
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    return 1'b0;
  endfunction

  function automatic void model_clear(input bit clear_rr);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      if (clear_rr) m_rr[s] = 0;
    end
  endfunction

  // Memory: accepts a refill request after a random delay and returns beats with random gaps.
  initial begin
    logic [63:0] line;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rlast     = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk); #2;
      if (mem_req_valid) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        line = mem_addr;
        last_mem_addr = mem_addr;
        mem_req_ready = 1'b1;
        mem_req_cnt++;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < LINE_BEATS; b++) begin
          repeat ($urandom_range(0, 1)) @(negedge clk);
          cur_beat   = b;
          mem_rvalid = 1'b1;
          mem_rdata  = beat_data(line + 64'(b * 8));
          mem_rlast  = (b == LINE_BEATS - 1);
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rlast  = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [63:0] pc);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("req_accepted", 64'(req_ready), 64'd1);
  endtask

  task automatic fetch(input logic [63:0] pc, input bit exp_hit);
    int c0, n;
    c0 = mem_req_cnt;
    resp_ready = 1'b1;
    issue(pc);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n = 0;
    while (!resp_valid && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("resp_pc", resp_pc, pc);
    check("resp_inst", 64'(resp_inst), 64'(exp_inst(pc)));
    check("refill_count", 64'(mem_req_cnt - c0), exp_hit ? 64'd0 : 64'd1);
    if (exp_hit) check("hit_latency", 64'(n), 64'd0);
  endtask

  task automatic fetch_dir(input logic [63:0] pc, input bit exp_hit);
    void'(model_access(pc));
    fetch(pc, exp_hit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pcs [3];
    logic [63:0] pc;
    int c0, n, seen;
`ifdef YSYX_22051013_ICACHE_PERF_EN
    logic [63:0] s0;
`endif
    req_valid = 1'b0; req_pc = '0; resp_ready = 1'b1;
    flush = 1'b0; fence_i = 1'b0; rst = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_resp_inst", 64'(resp_inst), 64'd0);
    check("rst_resp_pc", resp_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Cold miss
    fetch_dir(64'h8000_0004, 1'b0);
    check("cold_mem_addr", last_mem_addr, 64'h8000_0000);

    // Hit streaming
    pcs[0] = 64'h8000_0000; pcs[1] = 64'h8000_0004; pcs[2] = 64'h8000_0008;
    c0 = mem_req_cnt;
    issue(pcs[0]);
    for (int i = 0; i < 3; i++) begin
      void'(model_access(pcs[i]));
      @(negedge clk);
      if (i < 2) req_pc = pcs[i + 1];
      else       req_valid = 1'b0;
      #1;
      check("stream_valid", 64'(resp_valid), 64'd1);
      check("stream_pc", resp_pc, pcs[i]);
      check("stream_inst", 64'(resp_inst), 64'(exp_inst(pcs[i])));
    end
    check("stream_refills", 64'(mem_req_cnt - c0), 64'd0);

    // Replacement in set 0
    fetch_dir(64'h8000_0400, 1'b0);
    fetch_dir(64'h8000_0800, 1'b0);
    fetch_dir(64'h8000_0000, 1'b0);
    fetch_dir(64'h8000_0808, 1'b1);
    fetch_dir(64'h8000_0404, 1'b0);

    // Flush during the last refill beat
    c0 = mem_req_cnt;
    seen = 0;
    issue(64'h8000_0050);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n = 0;
    while (!(mem_rvalid && cur_beat == 1) && n < 300) begin
      if (resp_valid) seen++;
      @(negedge clk); #1;
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      @(negedge clk); #1;
    end
    check("flush_refill_resp", 64'(seen), 64'd0);
    check("flush_refill_reqs", 64'(mem_req_cnt - c0), 64'd1);
    void'(model_access(64'h8000_0050));
    fetch_dir(64'h8000_0054, 1'b1);

    // Flush in LOOKUP, then flush racing a request in IDLE
    issue(64'h8000_0058);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_lookup_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_lookup_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_pc = 64'h8000_0058;
    flush = 1'b1;
    #1;
    check("flush_wins_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_wins_no_resp", 64'(resp_valid), 64'd0);

    // Consumer stall on a hit
    void'(model_access(64'h8000_005c));
    resp_ready = 1'b0;
    issue(64'h8000_005c);
`ifdef YSYX_22051013_ICACHE_PERF_EN
    s0 = perf_stall;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_inst", 64'(resp_inst), 64'(exp_inst(64'h8000_005c)));
      check("stall_pc", resp_pc, 64'h8000_005c);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("stall_release", 64'(resp_valid), 64'd1);
`ifdef YSYX_22051013_ICACHE_PERF_EN
    check("perf_stall_delta", perf_stall - s0, 64'd5);
`endif

    // fence_i: SETS cycles busy, then previously cached PC misses
    @(negedge clk);
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    check("fence_busy_cycles", 64'(n), 64'(SETS));
    model_clear(1'b0);
    fetch_dir(64'h8000_0054, 1'b0);

    // Reset in the middle of a refill
    issue(64'h8000_0100);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n = 0;
    while (!mem_rvalid && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_refill_mreq", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    model_clear(1'b1);
    fetch_dir(64'h8000_0104, 1'b0);

    // Random fetches over 4 sets x 4 tags
    for (int i = 0; i < 150; i++) begin
      pc = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64'h400
         + 64'($urandom_range(0, 3)) * LINE_BYTES + 64'($urandom_range(0, LINE_BEATS * 2 - 1)) * 64'd4;
      fetch(pc, model_access(pc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
